uart_tx_feeder: RTL and testbench

//  Byte FIFO and send sequencer sitting directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder.sv | 130 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a UART transmitter.
// Bytes are issued one at a time and paced by the UART's transmission-in-progress flag.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_err,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  push, pop;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            data_q, data_d;
    logic                  send_q, send_d;
    logic                  err_q, err_d;

    assign level    = level_q;
    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign tx_data  = data_q;
    assign tx_send  = send_q;
    assign tx_err   = err_q;

    // Write acceptance looks only at full, so a same-cycle pop never frees a slot early.
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                level_q <= level_q + LVL_ONE;
            else if (pop && !push)
                level_q <= level_q - LVL_ONE;
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            send_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            send_q  <= send_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        send_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // Waiting for !tx_busy also lets a frame started before a reset finish.
                if (pop) begin
                    data_d  = mem[rd_ptr];
                    send_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (!tx_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized scoreboard bench for uart_tx_feeder with a behavioural FIFO/UART model.
module tb_uart_tx_feeder;
    localparam int DL = 4;
    localparam int DEPTH = 1 << DL;
    localparam int BT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full, empty, overflow, tx_err, tx_send;
    logic [DL:0]   level;
    logic [7:0]    tx_data;
    logic          tx_busy;

    logic          tip = 1'b0;
    logic          tip_force;
    logic          uart_ignore;
    int            frame_fixed;

    int            checks = 0;
    int            errors = 0;

    logic [7:0]    exp_q[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;
    logic          prev_send = 1'b0;

    assign tx_busy = tip | tip_force;

    uart_tx_feeder #(.DEPTH_LOG2(DL), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_err(tx_err), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is pushes minus issued sends; the queue holds accepted bytes in order.
    initial begin
        logic rst_s, we_s, busy_s, acc;
        logic [7:0] wd_s;
        forever begin
            @(posedge clk);
            rst_s = rst; we_s = wr_en; wd_s = wr_data; busy_s = tx_busy;
            #2;
            if (rst_s) begin
                m_cnt = 0;
                exp_q.delete();
                m_ovf = 1'b0;
            end else begin
                acc = we_s && (m_cnt < DEPTH);
                if (we_s && !acc) m_ovf = 1'b1;
                if (acc) exp_q.push_back(wd_s);
                if (tx_send === 1'b1) begin
                    chk("send_while_busy", busy_s, 0);
                    chk("send_back_to_back", prev_send, 0);
                    chk("send_from_empty", m_cnt != 0, 1);
                    if (m_cnt != 0) m_cnt--;
                end
                if (acc) m_cnt++;
            end
            prev_send = tx_send;
            chk("level", level, m_cnt);
            chk("full", full, m_cnt == DEPTH);
            chk("empty", empty, m_cnt == 0);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Monitor: every issued byte must be the oldest accepted one.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                chk("send_has_expected_byte", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e);
                end
            end
        end
    end

    // UART model: TiP rises two cycles after the send pulse and stays up for a frame.
    initial begin
        int fl;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1 && !uart_ignore) begin
                fl = (frame_fixed != 0) ? frame_fixed : int'($urandom_range(2, 10));
                @(posedge clk);
                @(posedge clk);
                #1 tip = 1'b1;
                repeat (fl) @(posedge clk);
                #1 tip = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int max);
        int quiet = 0;
        for (int i = 0; i < max && quiet < 12; i++) begin
            @(negedge clk);
            if (empty && !tx_busy && !tx_send) quiet++;
            else quiet = 0;
        end
        chk("drain_timeout", quiet >= 12, 1);
    endtask

    task automatic wait_send(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wr1(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
    endtask

    initial begin
        bit ok;
        int pct;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        tip_force = 1'b0; uart_ignore = 1'b0; frame_fixed = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();

        // Single byte latency
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("t1_empty_after_write", empty, 0);
        chk("t1_no_send_yet", tx_send, 0);
        @(negedge clk);
        chk("t1_send_pulse", tx_send, 1);
        chk("t1_data", tx_data, 8'hA5);
        wait_idle(100);
        chk("t1_empty_end", empty, 1);

        // Burst of three
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle(200);
        chk("t2_no_err", tx_err, 0);

        // Fill with TiP held high, then one extra write
        tip_force = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("t3_full", full, 1);
        chk("t3_overflow", overflow, 1);
        chk("t3_level", level, DEPTH);
        chk("t3_no_send", tx_send, 0);
        tip_force = 1'b0;
        wait_idle(600);
        chk("t3_overflow_sticky", overflow, 1);

        // Simultaneous write and pop at level 5
        tip_force = 1'b1;
        for (int i = 0; i < 5; i++) wr1(8'($urandom));
        wr_en = 1'b1; wr_data = 8'h5E; tip_force = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        chk("t4_level_held", level, 5);
        chk("t4_send", tx_send, 1);
        wait_idle(300);

        // TiP never rises: timeout flag, next byte still issued
        uart_ignore = 1'b1;
        wr1(8'hC3);
        wait_send(10, ok);
        chk("t5_send_seen", ok, 1);
        repeat (BT - 1) @(negedge clk);
        chk("t5_err_not_early", tx_err, 0);
        repeat (3) @(negedge clk);
        chk("t5_err_set", tx_err, 1);
        uart_ignore = 1'b0;
        wr1(8'h7D);
        wait_send(20, ok);
        chk("t5_next_send", ok, 1);
        wait_idle(200);
        chk("t5_err_sticky", tx_err, 1);

        // Reset in the middle of a long frame
        frame_fixed = 30;
        wr1(8'h11);
        wait_send(20, ok);
        chk("t6_send_seen", ok, 1);
        frame_fixed = 0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();
        wr1(8'h3C);
        wait_send(60, ok);
        chk("t6_send_after_frame", ok, 1);
        chk("t6_tip_low_at_send", tip, 0);
        wait_idle(200);

        // Random traffic at varying write densities
        for (int blk = 0; blk < 4; blk++) begin
            pct = (blk == 0) ? 10 : (blk == 1) ? 40 : (blk == 2) ? 90 : 20;
            for (int c = 0; c < 500; c++) begin
                wr_en = ($urandom_range(0, 99) < pct);
                wr_data = 8'($urandom);
                @(negedge clk);
            end
        end
        wr_en = 1'b0;
        wait_idle(2000);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog_timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
